ps2_rx_fifo: RTL and testbench

Receive side of the PS/2 keyboard path. The block oversamples the raw `ps2_clk`/`ps2_data` lines driven by the keyboard (the bench keyboard model in simulation, the board pins in hardware) on the system clock and deframes 11-bit PS/2 frames. It checks start, odd parity and stop bits, and buffers valid scan-code bytes in a small FIFO. Consumers such as the keyboard MMIO device read bytes through a ready/pop handshake.

---
 rtl/ps2_rx_fifo.sv | 166 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 receive path: synchronises the raw keyboard lines, deframes 11-bit frames
// with start/odd-parity/stop checking and buffers good scan-code bytes in a FIFO.
module ps2_rx_fifo #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       pop,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
   localparam logic [TW-1:0] IDLE_ONE  = TW'(1);
   localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [3:0]    LAST_BIT  = 4'd10;

   // Synchronisers
   logic [2:0] ck_s_q, ck_s_d;
   logic       d_meta_q;
   logic       d_s_q;

   // Deframer
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    sh_q, sh_d;
   logic [TW-1:0] idle_q, idle_d;

   // FIFO
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   logic          frame_err_q, frame_err_d;

   logic fall;
   logic frame_done;
   logic frame_valid;
   logic empty;
   logic full;
   logic do_pop;
   logic push;
   logic ovf_event;

   always_comb begin
      ck_s_d = {ck_s_q[1:0], ps2_clk};
      fall   = ck_s_q[2] & ~ck_s_q[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ck_s_q   <= 3'b111;
         d_meta_q <= 1'b1;
         d_s_q    <= 1'b1;
      end else begin
         ck_s_q   <= ck_s_d;
         d_meta_q <= ps2_data;
         d_s_q    <= d_meta_q;
      end
   end

   // The stop bit is not stored; it is the live d_s at the eleventh fall.
   always_comb begin
      frame_done  = fall && (bit_cnt_q == LAST_BIT);
      frame_valid = ~sh_q[0] & d_s_q & (^sh_q[9:1]);
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      idle_d    = idle_q;
      if (fall) begin
         idle_d = '0;
         if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
         end else begin
            sh_d[bit_cnt_q] = d_s_q;
            bit_cnt_d       = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         // Abandon a stalled partial frame silently.
         if (idle_q == IDLE_MAX) begin
            bit_cnt_d = '0;
            idle_d    = '0;
         end else begin
            idle_d = idle_q + IDLE_ONE;
         end
      end else begin
         idle_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q <= '0;
         sh_q      <= '0;
         idle_q    <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         sh_q      <= sh_d;
         idle_q    <= idle_d;
      end
   end

   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop    = pop & ~empty;
      push      = frame_done & frame_valid & (~full | do_pop);
      ovf_event = frame_done & frame_valid & full & ~do_pop;
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      frame_err_d = frame_done & ~frame_valid;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         overflow_d = 1'b0;
      end
      if (ovf_event) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= sh_q[8:1];
      end
   end

   always_comb begin
      data      = mem_q[rd_ptr_q[AW-1:0]];
      ready     = ~empty;
      overflow  = overflow_q;
      frame_err = frame_err_q;
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a table of single-frame cases plus hand-written
// sequences for latency, overflow, full-with-pop, timeout and mid-frame reset.
module tb_ps2_rx_fifo;

   logic       clk;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic       pop;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   int checks;
   int failures;
   int err_pulses;

   ps2_rx_fifo #(
      .FIFO_DEPTH     (8),
      .TIMEOUT_CYCLES (4096)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .pop       (pop),
      .data      (data),
      .ready     (ready),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   // Posedges land on odd times; all stimulus changes happen on even times.
   initial clk = 1'b0;
   always #1 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) err_pulses++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] b;
      logic       par_flip;
      logic       stop;
      logic       exp_ready;
      logic [7:0] exp_data;
      int         exp_err;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b, input logic pf, input logic st);
      return {st, (~^b) ^ pf, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         #16 ps2_clk = 1'b0;
         #30 ps2_clk = 1'b1;
         #14;
      end
      ps2_data = 1'b1;
   endtask

   task automatic do_pop();
      pop = 1'b1;
      #2 pop = 1'b0;
   endtask

   initial begin
      int e0;
      logic [10:0] f;
      checks     = 0;
      failures   = 0;
      err_pulses = 0;

      vecs[0] = '{b: 8'h1C, par_flip: 1'b0, stop: 1'b1, exp_ready: 1'b1, exp_data: 8'h1C, exp_err: 0};
      vecs[1] = '{b: 8'h1C, par_flip: 1'b1, stop: 1'b1, exp_ready: 1'b0, exp_data: 8'h00, exp_err: 1};
      vecs[2] = '{b: 8'h1C, par_flip: 1'b0, stop: 1'b0, exp_ready: 1'b0, exp_data: 8'h00, exp_err: 1};
      vecs[3] = '{b: 8'hA5, par_flip: 1'b0, stop: 1'b1, exp_ready: 1'b1, exp_data: 8'hA5, exp_err: 0};
      vecs[4] = '{b: 8'h00, par_flip: 1'b0, stop: 1'b1, exp_ready: 1'b1, exp_data: 8'h00, exp_err: 0};
      vecs[5] = '{b: 8'hFF, par_flip: 1'b0, stop: 1'b1, exp_ready: 1'b1, exp_data: 8'hFF, exp_err: 0};

      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      pop      = 1'b0;
      rst_n    = 1'b0;
      #5;
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      #5 rst_n = 1'b1;
      #10;

      // Exact latency of the stop-bit edge to ready/data.
      f = mk(8'h1C, 1'b0, 1'b1);
      send_bits(f, 10);
      ps2_data = 1'b1;
      #16 ps2_clk = 1'b0;
      #4;
      check("lat_ready_early", {31'd0, ready}, 32'd0);
      #2;
      check("lat_ready", {31'd0, ready}, 32'd1);
      check("lat_data", {24'd0, data}, 32'h1C);
      #24 ps2_clk = 1'b1;
      #14;
      check("lat_no_err", err_pulses, 0);
      check("lat_no_ovf", {31'd0, overflow}, 32'd0);
      do_pop();
      check("lat_pop_empty", {31'd0, ready}, 32'd0);

      for (int i = 0; i < 6; i++) begin
         e0 = err_pulses;
         send_bits(mk(vecs[i].b, vecs[i].par_flip, vecs[i].stop), 11);
         #10;
         check($sformatf("vec%0d_ready", i), {31'd0, ready}, {31'd0, vecs[i].exp_ready});
         if (vecs[i].exp_ready) begin
            check($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, vecs[i].exp_data});
         end
         check($sformatf("vec%0d_err", i), err_pulses - e0, vecs[i].exp_err);
         check($sformatf("vec%0d_ovf", i), {31'd0, overflow}, 32'd0);
         if (vecs[i].exp_ready) do_pop();
      end

      // Burst ordering.
      send_bits(mk(8'hF0, 1'b0, 1'b1), 11);
      send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
      check("burst_first", {24'd0, data}, 32'hF0);
      do_pop();
      check("burst_second", {24'd0, data}, 32'h1C);
      check("burst_ready_mid", {31'd0, ready}, 32'd1);
      do_pop();
      check("burst_empty", {31'd0, ready}, 32'd0);

      // Overflow: ninth byte is dropped.
      for (int i = 1; i <= 9; i++) send_bits(mk(8'(i), 1'b0, 1'b1), 11);
      check("ovf_set", {31'd0, overflow}, 32'd1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_data%0d", i), {24'd0, data}, i);
         do_pop();
         if (i == 1) check("ovf_cleared", {31'd0, overflow}, 32'd0);
      end
      check("ovf_drained", {31'd0, ready}, 32'd0);

      // Full with a pop in the cycle the ninth stop edge is processed.
      for (int i = 1; i <= 8; i++) send_bits(mk(8'(i), 1'b0, 1'b1), 11);
      send_bits(mk(8'h09, 1'b0, 1'b1), 10);
      ps2_data = 1'b1;
      #16 ps2_clk = 1'b0;
      #4 pop = 1'b1;
      #2 pop = 1'b0;
      #24 ps2_clk = 1'b1;
      #14;
      check("fullpop_no_ovf", {31'd0, overflow}, 32'd0);
      for (int i = 2; i <= 9; i++) begin
         check($sformatf("fullpop_data%0d", i), {24'd0, data}, i);
         do_pop();
      end
      check("fullpop_drained", {31'd0, ready}, 32'd0);

      // Timeout discards a partial frame.
      e0 = err_pulses;
      send_bits(mk(8'h55, 1'b0, 1'b1), 5);
      #(2 * (4096 + 10));
      send_bits(mk(8'h2A, 1'b0, 1'b1), 11);
      check("tmo_ready", {31'd0, ready}, 32'd1);
      check("tmo_data", {24'd0, data}, 32'h2A);
      check("tmo_no_err", err_pulses - e0, 0);
      do_pop();

      // Reset mid-frame with a byte already buffered.
      send_bits(mk(8'h77, 1'b0, 1'b1), 11);
      check("rst_pre_ready", {31'd0, ready}, 32'd1);
      send_bits(mk(8'h33, 1'b0, 1'b1), 4);
      rst_n = 1'b0;
      #1;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      #5 rst_n = 1'b1;
      #4;
      e0 = err_pulses;
      send_bits(mk(8'h33, 1'b0, 1'b1), 11);
      check("rst_post_ready", {31'd0, ready}, 32'd1);
      check("rst_post_data", {24'd0, data}, 32'h33);
      check("rst_post_err", err_pulses - e0, 0);
      do_pop();
      check("rst_post_empty", {31'd0, ready}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
